spi_txn_scheduler: RTL
======================

Name: spi_txn_scheduler

Overview:
- Command sequencer directly upstream of the SPI master. Drives the master's tx_data, tx_start, ss, i_mode_set and SPI_MODE inputs, and consumes its rx_data and spic (transfer-complete).
- Buffers byte commands in a command FIFO and issues them one at a time, reprogramming the SPI mode only when needed.
- Captures each received byte into a response FIFO for the host side.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
MODE_SETTLE, 2, idle cycles between m_mode_set pulse and m_tx_start (>=1)
TIMEOUT_CYC, 1024, max cycles to wait for completion after m_tx_start; 0 disables timeout

Ports:
P_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-low reset (0 = reset)
cmd_valid  in  1  command present
cmd_ready  out  1  command FIFO not full
cmd_data  in  8  byte to transmit
cmd_ss  in  2  slave select index
cmd_mode  in  2  SPI mode {CPOL,CPHA}
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  host pops response
rsp_data  out  8  received byte (head of FIFO)
rsp_ss  out  2  slave index of that byte
rsp_err  out  1  1 = transfer timed out, rsp_data = 8'h00
m_tx_data  out  8  to master tx_data
m_tx_start  out  1  to master tx_start, 1-cycle pulse
m_ss  out  2  to master ss
m_mode_set  out  1  to master i_mode_set, 1-cycle pulse
m_spi_mode  out  2  to master SPI_MODE
m_rx_data  in  8  from master rx_data
m_spic  in  1  from master spic (transfer complete)
busy  out  1  FSM not IDLE or command FIFO non-empty

Behaviour:
- Reset (reset==0 at a clock edge): both FIFOs emptied; FSM to IDLE; all outputs 0 except cmd_ready=1; mode_valid flag cleared. Reset mid-transfer aborts it silently, with no response pushed.
- Command push on cmd_valid&&cmd_ready. cmd_ready=!cmd_full. Response pop on rsp_valid&&rsp_ready. Each FIFO supports push and pop in the same cycle; at full only the pop side is open. FIFOs are first-word-fall-through and never reorder.
- m_spic completion = rising edge of m_spic (registered previous value); level is ignored.
- FSM states:
  - IDLE: if command FIFO non-empty, pop it and register data/ss/mode into m_tx_data/m_ss/m_spi_mode. Go to MODE if !mode_valid or mode differs from last applied mode or ss differs from last ss; else go to START.
  - MODE: m_mode_set=1 for one cycle; set mode_valid; go to MODE_WAIT.
  - MODE_WAIT: wait MODE_SETTLE cycles, then go to START.
  - START: m_tx_start=1 for one cycle; clear timeout counter; go to WAIT_DONE.
  - WAIT_DONE: on m_spic rise, latch m_rx_data with err=0 and go to PUSH. If TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC, latch 8'h00 with err=1 and go to PUSH.
  - PUSH: if response FIFO not full, push {data, ss, err} and go to IDLE; else stall in PUSH, holding the latched entry.
- m_tx_data/m_ss/m_spi_mode stay stable from the IDLE pop until the next pop.
- Latency, command accepted at edge A into an empty FIFO in IDLE:
  - no mode change: m_tx_start high in cycle A+2.
  - mode change: m_mode_set in A+2, m_tx_start in A+3+MODE_SETTLE.
  - Response is visible (rsp_valid) 2 cycles after the m_spic rise if the response FIFO has room.
- A m_spic rise outside WAIT_DONE is ignored.
- Counters wrap-safe: FIFO pointers carry one extra bit for full/empty detection.

Test Plan:
1. Post-reset, cmd {AA, ss0, mode0}; bench master model returns BB with spic -> one m_mode_set pulse; m_tx_start at A+3+MODE_SETTLE; rsp {BB, ss0, err0}.
2. Follow-up cmd {55, ss0, mode0} -> no m_mode_set; m_tx_start at A+2; rsp 0x55 echo from model.
3. cmd {77, ss1, mode3}, model returns 88 -> m_mode_set pulse; m_spi_mode=3 and m_ss=1 held through the transfer; rsp {88, ss1, err0}.
4. rsp_ready=0, stream 10 commands back-to-back with model completing each -> exactly 9 accepted (4 in rsp FIFO, 1 stalled in PUSH, 4 in cmd FIFO), cmd_ready=0 on the 10th. Raise rsp_ready -> 9 responses delivered in order, busy falls.
5. TIMEOUT_CYC=64, model never pulses spic -> rsp {00, err1} pushed 64 cycles after m_tx_start; the next command then proceeds normally.
6. Assert reset in WAIT_DONE -> next edge all outputs 0, cmd_ready=1, rsp_valid=0. Next command forces m_mode_set even with an unchanged mode.

Source files
------------

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: buffers byte commands, sequences them one at a time into
// an SPI master (reprogramming the SPI mode only when mode or slave changes),
// and collects each received byte into a response FIFO for the host.
module spi_txn_scheduler #(
  parameter int CMD_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int MODE_SETTLE = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       P_clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic [1:0] cmd_ss,
  input  logic [1:0] cmd_mode,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_ss,
  output logic       rsp_err,
  output logic [7:0] m_tx_data,
  output logic       m_tx_start,
  output logic [1:0] m_ss,
  output logic       m_mode_set,
  output logic [1:0] m_spi_mode,
  input  logic [7:0] m_rx_data,
  input  logic       m_spic,
  output logic       busy
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int SW  = (MODE_SETTLE > 1) ? $clog2(MODE_SETTLE) : 1;
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(MODE_SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit            TIMEOUT_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MODE,
    S_MODE_WAIT,
    S_START,
    S_WAIT_DONE,
    S_PUSH
  } state_t;

  state_t          state_q;
  logic [7:0]      m_tx_data_q;
  logic [1:0]      m_ss_q;
  logic [1:0]      m_spi_mode_q;
  logic            m_mode_set_q;
  logic            m_tx_start_q;
  logic            mode_valid_q;
  logic [SW-1:0]   settle_cnt_q;
  logic [TW-1:0]   to_cnt_q;
  logic [7:0]      lat_data_q;
  logic            lat_err_q;
  logic            spic_prev_q;

  // Command FIFO: entry layout is {data[7:0], ss[1:0], mode[1:0]}
  logic [11:0]     cmd_mem_q [CMD_DEPTH];
  logic [CAW:0]    cmd_wr_q, cmd_wr_d;
  logic [CAW:0]    cmd_rd_q, cmd_rd_d;
  logic            cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic [11:0]     cmd_head;

  // Response FIFO: entry layout is {data[7:0], ss[1:0], err}
  logic [10:0]     rsp_mem_q [RSP_DEPTH];
  logic [RAW:0]    rsp_wr_q, rsp_wr_d;
  logic [RAW:0]    rsp_rd_q, rsp_rd_d;
  logic            rsp_empty, rsp_full, rsp_push, rsp_pop;
  logic [10:0]     rsp_head;

  logic            spic_rise;
  logic            need_mode;

  assign cmd_empty = (cmd_wr_q == cmd_rd_q);
  assign cmd_full  = (cmd_wr_q[CAW] != cmd_rd_q[CAW]) &&
                     (cmd_wr_q[CAW-1:0] == cmd_rd_q[CAW-1:0]);
  assign cmd_push  = cmd_valid && !cmd_full;
  assign cmd_pop   = (state_q == S_IDLE) && !cmd_empty;
  assign cmd_head  = cmd_mem_q[cmd_rd_q[CAW-1:0]];

  assign rsp_empty = (rsp_wr_q == rsp_rd_q);
  assign rsp_full  = (rsp_wr_q[RAW] != rsp_rd_q[RAW]) &&
                     (rsp_wr_q[RAW-1:0] == rsp_rd_q[RAW-1:0]);
  assign rsp_push  = (state_q == S_PUSH) && !rsp_full;
  assign rsp_pop   = !rsp_empty && rsp_ready;
  assign rsp_head  = rsp_mem_q[rsp_rd_q[RAW-1:0]];

  // Only a fresh low-to-high transition of the master's done flag counts
  assign spic_rise = m_spic && !spic_prev_q;

  // Reprogram the master whenever nothing has been applied yet or the target changes
  assign need_mode = !mode_valid_q ||
                     (cmd_head[1:0] != m_spi_mode_q) ||
                     (cmd_head[3:2] != m_ss_q);

  // Next-state pointer arithmetic for both FIFOs
  always_comb begin
    cmd_wr_d = cmd_wr_q;
    cmd_rd_d = cmd_rd_q;
    rsp_wr_d = rsp_wr_q;
    rsp_rd_d = rsp_rd_q;
    if (cmd_push) cmd_wr_d = cmd_wr_q + 1'b1;
    if (cmd_pop)  cmd_rd_d = cmd_rd_q + 1'b1;
    if (rsp_push) rsp_wr_d = rsp_wr_q + 1'b1;
    if (rsp_pop)  rsp_rd_d = rsp_rd_q + 1'b1;
  end

  // FIFO pointers, emptied on reset
  always_ff @(posedge P_clk) begin
    if (!reset) begin
      cmd_wr_q <= '0;
      cmd_rd_q <= '0;
      rsp_wr_q <= '0;
      rsp_rd_q <= '0;
    end else begin
      cmd_wr_q <= cmd_wr_d;
      cmd_rd_q <= cmd_rd_d;
      rsp_wr_q <= rsp_wr_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  // Command storage; contents are only meaningful between the pointers
  always_ff @(posedge P_clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q[CAW-1:0]] <= {cmd_data, cmd_ss, cmd_mode};
  end

  // Response storage; written with the entry latched at transfer end
  always_ff @(posedge P_clk) begin
    if (rsp_push) rsp_mem_q[rsp_wr_q[RAW-1:0]] <= {lat_data_q, m_ss_q, lat_err_q};
  end

  // Transaction sequencer with registered master-side outputs
  always_ff @(posedge P_clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      m_tx_data_q  <= '0;
      m_ss_q       <= '0;
      m_spi_mode_q <= '0;
      m_mode_set_q <= 1'b0;
      m_tx_start_q <= 1'b0;
      mode_valid_q <= 1'b0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      lat_data_q   <= '0;
      lat_err_q    <= 1'b0;
      spic_prev_q  <= 1'b0;
    end else begin
      spic_prev_q  <= m_spic;
      m_mode_set_q <= 1'b0;
      m_tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!cmd_empty) begin
            m_tx_data_q  <= cmd_head[11:4];
            m_ss_q       <= cmd_head[3:2];
            m_spi_mode_q <= cmd_head[1:0];
            state_q      <= need_mode ? S_MODE : S_START;
          end
        end
        S_MODE: begin
          m_mode_set_q <= 1'b1;
          mode_valid_q <= 1'b1;
          settle_cnt_q <= '0;
          state_q      <= S_MODE_WAIT;
        end
        S_MODE_WAIT: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= S_START;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        S_START: begin
          m_tx_start_q <= 1'b1;
          to_cnt_q     <= '0;
          state_q      <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (spic_rise) begin
            lat_data_q <= m_rx_data;
            lat_err_q  <= 1'b0;
            state_q    <= S_PUSH;
          end else if (TIMEOUT_EN && (to_cnt_q == TIMEOUT_LAST)) begin
            lat_data_q <= 8'h00;
            lat_err_q  <= 1'b1;
            state_q    <= S_PUSH;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_PUSH: begin
          if (!rsp_full) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !cmd_full;
  assign rsp_valid  = !rsp_empty;
  assign rsp_data   = rsp_empty ? 8'h00 : rsp_head[10:3];
  assign rsp_ss     = rsp_empty ? 2'b00 : rsp_head[2:1];
  assign rsp_err    = rsp_empty ? 1'b0  : rsp_head[0];
  assign m_tx_data  = m_tx_data_q;
  assign m_tx_start = m_tx_start_q;
  assign m_ss       = m_ss_q;
  assign m_mode_set = m_mode_set_q;
  assign m_spi_mode = m_spi_mode_q;
  assign busy       = (state_q != S_IDLE) || !cmd_empty;

endmodule
